mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single main-memory port of the processor between the instruction cache (line-fill reads) and the data cache (line-fill reads and write-backs). It sits between the two cache miss controllers and the external memory interface. It owns one memory transaction at a time, sequences its request, write-data and read-response beats, and steers read responses back to the owning cache. Fetch and decode stall on icache misses, so a starved icache freezes the pipeline; round-robin fairness is therefore mandatory.

## Interface
- ADDR_W, 28, line address width
- DATA_W, 128, beat width
- BEATS, 4, beats per line (power of two, ≥2)
- TAG_W, 4, memory tag width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ic_req_valid / ic_req_ready  in / out  1  icache read request handshake
- ic_req_addr  in  ADDR_W  icache line address
- ic_resp_valid / ic_resp_data  out  1 / DATA_W  icache response beat
- dc_req_valid / dc_req_ready  in / out  1  dcache request handshake
- dc_req_rw  in  1  1 = write-back, 0 = fill
- dc_req_addr  in  ADDR_W  dcache line address
- dc_wdata_valid / dc_wdata_ready  in / out  1  dcache write-data handshake
- dc_wdata / dc_wmask  in  DATA_W / DATA_W/8  write beat and byte mask
- dc_resp_valid / dc_resp_data  out  1 / DATA_W  dcache response beat
- mem_req_valid / mem_req_ready  out / in  1  memory request handshake
- mem_req_rw / mem_req_addr / mem_req_tag  out  1 / ADDR_W / TAG_W  request fields
- mem_wdata_valid / mem_wdata_ready  out / in  1  memory write-data handshake
- mem_wdata / mem_wmask  out  DATA_W / DATA_W/8
- mem_resp_valid / mem_resp_tag / mem_resp_data  in  1 / TAG_W / DATA_W  read response beat

## Operation
- States: IDLE, REQ, WDATA, RRESP.
- IDLE: grant when any request is valid. Single requester: grant it. Both valid: grant the one not granted last. The last_grant register resets to IC, so dcache wins the first tie.
- Grant cycle: the granted *_req_ready is 1 (combinational from state==IDLE and grant). Addr, rw (icache rw=0) and owner are captured into registers. Next state is REQ.
- REQ: mem_req_valid=1. Fields come from the registers. mem_req_tag = TAG_IC (0) or TAG_DC (1). On mem_req_ready, go to WDATA if rw=1, otherwise to RRESP.
- WDATA: combinational passthrough. mem_wdata_valid=dc_wdata_valid, dc_wdata_ready=mem_wdata_ready, data and mask pass through. The beat counter increments on each handshake. After the BEATS-th handshake, go to IDLE.
- RRESP: a beat with mem_resp_valid=1 and mem_resp_tag equal to the owner tag is forwarded the same cycle to the owner's resp_valid/resp_data, and counted. A beat whose tag mismatches is dropped, not counted, and sets the sticky status bit err_tag. After the BEATS-th counted beat, go to IDLE.
- Outside RRESP, responses are dropped.
- The non-owner's *_req_ready and resp_valid stay 0 for the whole transaction. The non-owner's request remains pending and wins the next IDLE arbitration.
- Beat counter is $clog2(BEATS) bits. It wraps to 0 on the last beat and is never read as BEATS.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=IDLE, counter=0, last_grant=IC, err_tag=0.
  - All valid/ready outputs 0.
  - mem_req_addr, mem_req_rw, mem_req_tag and the captured registers are 0.
- Reset mid-transaction abandons the transaction immediately. Late memory responses are dropped in IDLE.
- Latency:
  - Grant to mem_req_valid: 1 cycle.
  - Read line: mem ack plus BEATS counted response cycles, then 1 cycle in IDLE before the next grant.
  - Minimum idle-to-idle for a read: 2+BEATS cycles.
- mem_req_valid holds stable, with stable fields, until mem_req_ready. The block never retracts a request.
- A request arriving in the same cycle a transaction completes is granted in the following IDLE cycle, never the completion cycle.
- Responses and write data pass through combinationally with no extra latency. No buffering.

## Structure
- Shared package mem_arb_pkg holds: the state enum (IDLE, REQ, WDATA, RRESP), the owner enum (OWN_IC, OWN_DC), and the constants TAG_IC=0 and TAG_DC=1.
- One sub-module, mem_beat_counter: parameter BEATS; inputs inc and clr; output last. This is the only counting logic. The FSM and the round-robin pick stay in mem_arbiter.

## Test plan
- Lone icache read, addr 0x0000123, memory ready immediately, 4 response beats tag 0 → mem_req_valid in cycle 1, 4 ic_resp_valid pulses, dc_resp_valid never asserted, IDLE after beat 4.
- Both caches valid in the first cycle after reset → dcache granted first. Icache granted at the next IDLE. Then, with both still valid, dcache again: strict alternation.
- Dcache write-back addr 0x0ABCDEF, mem_wdata_ready toggling 1/0 → exactly 4 write handshakes with data and mask unchanged. No response expected. IDLE after the 4th handshake.
- mem_req_ready held low 10 cycles → mem_req_valid and its fields stay constant all 10 cycles. ic_req_ready stays 0 throughout.
- During an icache read, inject a beat with tag 1 between beats 2 and 3 → it is dropped, err_tag=1, the icache still receives exactly 4 beats.
- rst_n pulsed low after response beat 2 of 4 → all outputs 0 immediately, state IDLE. The remaining 2 beats are ignored. A new request is granted normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner enums and memory tag constants for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WDATA, RRESP} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;
  localparam int TAG_IC = 0;
  localparam int TAG_DC = 1;
endpackage

// File: rtl/mem_beat_counter.sv
// mem_beat_counter: counts line beats, flags the final beat of a line
// ports: clk, rst_n (async low); clr holds count at 0; inc advances; last = inc on beat BEATS-1
module mem_beat_counter #(
  parameter int BEATS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);
  localparam int CW = $clog2(BEATS);
  logic [CW-1:0] cnt;
  // BEATS is a power of two, so the increment on the last beat wraps to 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign last = inc && cnt == CW'(BEATS - 1);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter of the memory port between icache fills and dcache fills/write-backs
// ports: ic_req/ic_resp (icache), dc_req/dc_wdata/dc_resp (dcache), mem_req/mem_wdata/mem_resp (memory),
//        err_tag = sticky flag for a response beat whose tag did not match the owner
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ic_req_valid,
  output logic                ic_req_ready,
  input  logic [ADDR_W-1:0]   ic_req_addr,
  output logic                ic_resp_valid,
  output logic [DATA_W-1:0]   ic_resp_data,
  input  logic                dc_req_valid,
  output logic                dc_req_ready,
  input  logic                dc_req_rw,
  input  logic [ADDR_W-1:0]   dc_req_addr,
  input  logic                dc_wdata_valid,
  output logic                dc_wdata_ready,
  input  logic [DATA_W-1:0]   dc_wdata,
  input  logic [DATA_W/8-1:0] dc_wmask,
  output logic                dc_resp_valid,
  output logic [DATA_W-1:0]   dc_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [TAG_W-1:0]    mem_req_tag,
  output logic                mem_wdata_valid,
  input  logic                mem_wdata_ready,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [TAG_W-1:0]    mem_resp_tag,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                err_tag
);
  state_t state, state_d;
  owner_t owner, last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic rw_q, idle, pick_dc, grant, hit, wr_hs, last;
  logic [TAG_W-1:0] own_tag;
  // readies are gated by rst_n so nothing is granted while reset is held
  assign idle = state == IDLE && rst_n;
  assign pick_dc = dc_req_valid && (!ic_req_valid || last_grant == OWN_IC);
  assign grant = idle && (ic_req_valid || dc_req_valid);
  assign ic_req_ready = idle && ic_req_valid && !pick_dc;
  assign dc_req_ready = idle && pick_dc;
  assign own_tag = owner == OWN_DC ? TAG_W'(TAG_DC) : TAG_W'(TAG_IC);
  assign mem_req_valid = state == REQ;
  assign mem_req_rw = rw_q;
  assign mem_req_addr = addr_q;
  assign mem_req_tag = own_tag;
  assign mem_wdata_valid = state == WDATA && dc_wdata_valid;
  assign dc_wdata_ready = state == WDATA && mem_wdata_ready;
  assign mem_wdata = dc_wdata;
  assign mem_wmask = dc_wmask;
  assign wr_hs = mem_wdata_valid && mem_wdata_ready;
  assign hit = state == RRESP && mem_resp_valid && mem_resp_tag == own_tag;
  assign ic_resp_valid = hit && owner == OWN_IC;
  assign dc_resp_valid = hit && owner == OWN_DC;
  assign ic_resp_data = mem_resp_data;
  assign dc_resp_data = mem_resp_data;
  mem_beat_counter #(.BEATS(BEATS)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(state == IDLE), .inc(wr_hs || hit), .last(last)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = grant ? REQ : IDLE;
      REQ:     state_d = mem_req_ready ? (rw_q ? WDATA : RRESP) : REQ;
      WDATA:   state_d = last ? IDLE : WDATA;
      RRESP:   state_d = last ? IDLE : RRESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      owner <= OWN_IC;
      last_grant <= OWN_IC;
      addr_q <= '0;
      rw_q <= 1'b0;
      err_tag <= 1'b0;
    end else begin
      state <= state_d;
      if (grant) begin
        owner <= pick_dc ? OWN_DC : OWN_IC;
        last_grant <= pick_dc ? OWN_DC : OWN_IC;
        addr_q <= pick_dc ? dc_req_addr : ic_req_addr;
        rw_q <= pick_dc && dc_req_rw;
      end
      if (state == RRESP && mem_resp_valid && mem_resp_tag != own_tag) err_tag <= 1'b1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam logic [27:0] IC_A = 28'h0000123;
  localparam logic [27:0] DC_A = 28'h0ABCDEF;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ic_req_valid = 0, ic_req_ready, ic_resp_valid;
  logic [27:0] ic_req_addr = IC_A;
  logic [127:0] ic_resp_data;
  logic dc_req_valid = 0, dc_req_ready, dc_req_rw = 0, dc_wdata_valid = 0, dc_wdata_ready, dc_resp_valid;
  logic [27:0] dc_req_addr = DC_A;
  logic [127:0] dc_wdata = '0, dc_resp_data;
  logic [15:0] dc_wmask = '0;
  logic mem_req_valid, mem_req_ready = 0, mem_req_rw, mem_wdata_valid, mem_wdata_ready = 0;
  logic [27:0] mem_req_addr;
  logic [3:0] mem_req_tag, mem_resp_tag = '0;
  logic [127:0] mem_wdata, mem_resp_data = '0;
  logic [15:0] mem_wmask;
  logic mem_resp_valid = 0, err_tag;
  int passed = 0, total = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
    .dc_wdata(dc_wdata), .dc_wmask(dc_wmask), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
    .err_tag(err_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic ic;
    logic dc;
    logic exp_ic;
    logic exp_dc;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // called one cycle after a grant, with the arbiter in REQ
  task automatic serve_read(input logic is_dc, input logic [27:0] a);
    int n_ic, n_dc, bad;
    n_ic = 0; n_dc = 0; bad = 0;
    mem_req_ready = 1;
    #1;
    chk("req_valid", 128'(mem_req_valid), 128'd1);
    chk("req_addr", 128'(mem_req_addr), 128'(a));
    chk("req_tag", 128'(mem_req_tag), 128'(is_dc));
    chk("req_rw", 128'(mem_req_rw), 128'd0);
    tick;
    mem_req_ready = 0;
    for (int b = 0; b < 4; b++) begin
      mem_resp_valid = 1;
      mem_resp_tag = 4'(is_dc);
      mem_resp_data = 128'(32'hB000 + b);
      #1;
      n_ic += int'(ic_resp_valid);
      n_dc += int'(dc_resp_valid);
      if ((is_dc ? dc_resp_data : ic_resp_data) !== 128'(32'hB000 + b)) bad++;
      tick;
    end
    mem_resp_valid = 0;
    #1;
    chk("ic_beats", 128'(n_ic), is_dc ? 128'd0 : 128'd4);
    chk("dc_beats", 128'(n_dc), is_dc ? 128'd4 : 128'd0);
    chk("resp_data", 128'(bad), 128'd0);
  endtask

  initial begin
    int hs, bad, nresp, n_ic, stable;
    tbl[0] = '{1, 1, 0, 1};
    tbl[1] = '{1, 1, 1, 0};
    tbl[2] = '{1, 1, 0, 1};
    tbl[3] = '{1, 0, 1, 0};
    tbl[4] = '{1, 0, 1, 0};
    tbl[5] = '{0, 1, 0, 1};
    tbl[6] = '{1, 1, 1, 0};
    tbl[7] = '{0, 0, 0, 0};

    ic_req_valid = 1;
    #2;
    chk("rst_ctrl", 128'({ic_req_ready, ic_resp_valid, dc_req_ready, dc_resp_valid, dc_wdata_ready,
                          mem_req_valid, mem_wdata_valid, mem_req_rw, err_tag}), 128'd0);
    chk("rst_addr", 128'(mem_req_addr), 128'd0);
    chk("rst_tag", 128'(mem_req_tag), 128'd0);
    ic_req_valid = 0;
    tick;
    rst_n = 1;
    tick;

    foreach (tbl[i]) begin
      ic_req_valid = tbl[i].ic;
      dc_req_valid = tbl[i].dc;
      dc_req_rw = 0;
      #1;
      chk($sformatf("v%0d_ic_ready", i), 128'(ic_req_ready), 128'(tbl[i].exp_ic));
      chk($sformatf("v%0d_dc_ready", i), 128'(dc_req_ready), 128'(tbl[i].exp_dc));
      tick;
      ic_req_valid = 0;
      dc_req_valid = 0;
      if (tbl[i].exp_ic || tbl[i].exp_dc) serve_read(tbl[i].exp_dc, tbl[i].exp_dc ? DC_A : IC_A);
      else begin
        #1;
        chk("no_req_valid", 128'(mem_req_valid), 128'd0);
      end
    end

    // dcache write-back with memory ready toggling
    dc_req_valid = 1;
    dc_req_rw = 1;
    #1;
    chk("wb_grant", 128'(dc_req_ready), 128'd1);
    tick;
    dc_req_valid = 0;
    dc_req_rw = 0;
    mem_req_ready = 1;
    #1;
    chk("wb_req", 128'({mem_req_valid, mem_req_rw, mem_req_tag, mem_req_addr}), 128'({1'b1, 1'b1, 4'd1, DC_A}));
    tick;
    mem_req_ready = 0;
    hs = 0; bad = 0; nresp = 0;
    for (int c = 0; c < 20 && hs < 4; c++) begin
      dc_wdata_valid = 1;
      dc_wdata = {4{32'hD000 + 32'(hs)}};
      dc_wmask = 16'hA5A0 | 16'(hs);
      mem_wdata_ready = (c % 2) == 0;
      mem_resp_valid = 1;
      mem_resp_tag = 4'd1;
      #1;
      nresp += int'(dc_resp_valid) + int'(ic_resp_valid);
      if (mem_wdata_valid && mem_wdata_ready) begin
        if (!dc_wdata_ready || mem_wdata !== {4{32'hD000 + 32'(hs)}} || mem_wmask !== (16'hA5A0 | 16'(hs))) bad++;
        hs++;
      end
      tick;
    end
    mem_resp_valid = 0;
    mem_wdata_ready = 1;
    #1;
    chk("wb_handshakes", 128'(hs), 128'd4);
    chk("wb_passthru", 128'(bad), 128'd0);
    chk("wb_no_resp", 128'(nresp), 128'd0);
    chk("wb_idle", 128'({mem_wdata_valid, dc_wdata_ready}), 128'd0);
    dc_wdata_valid = 0;
    mem_wdata_ready = 0;

    // icache read: memory stalls 10 cycles, then a foreign-tag beat mid-line
    ic_req_valid = 1;
    #1;
    chk("stall_grant", 128'(ic_req_ready), 128'd1);
    tick;
    stable = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!(mem_req_valid && mem_req_addr == IC_A && mem_req_tag == 4'd0 && !mem_req_rw && !ic_req_ready)) stable = 0;
      tick;
    end
    chk("stall_stable", 128'(stable), 128'd1);
    chk("err_before", 128'(err_tag), 128'd0);
    ic_req_valid = 0;
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0;
    n_ic = 0;
    for (int k = 0; k < 5; k++) begin
      mem_resp_valid = 1;
      mem_resp_tag = (k == 2) ? 4'd1 : 4'd0;
      mem_resp_data = 128'(k);
      #1;
      n_ic += int'(ic_resp_valid);
      if (k == 2) chk("bad_tag_drop", 128'({ic_resp_valid, dc_resp_valid}), 128'd0);
      tick;
    end
    mem_resp_valid = 0;
    #1;
    chk("err_ic_beats", 128'(n_ic), 128'd4);
    chk("err_tag_set", 128'(err_tag), 128'd1);

    // reset pulsed after beat 2 of an icache read
    ic_req_valid = 1;
    #1;
    chk("rr_grant", 128'(ic_req_ready), 128'd1);
    tick;
    ic_req_valid = 0;
    mem_req_ready = 1;
    tick;
    mem_req_ready = 0;
    for (int k = 0; k < 2; k++) begin
      mem_resp_valid = 1;
      mem_resp_tag = 4'd0;
      tick;
    end
    rst_n = 0;
    #1;
    chk("mid_rst_ctrl", 128'({ic_req_ready, ic_resp_valid, dc_req_ready, dc_resp_valid, dc_wdata_ready,
                              mem_req_valid, mem_wdata_valid, mem_req_rw, err_tag}), 128'd0);
    chk("mid_rst_fields", 128'({mem_req_addr, mem_req_tag}), 128'd0);
    tick;
    rst_n = 1;
    n_ic = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_ic += int'(ic_resp_valid);
      tick;
    end
    mem_resp_valid = 0;
    chk("late_beats", 128'(n_ic), 128'd0);
    ic_req_valid = 1;
    #1;
    chk("post_rst_grant", 128'(ic_req_ready), 128'd1);
    tick;
    ic_req_valid = 0;
    serve_read(1'b0, IC_A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
